memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_array.sv | 29 ++
 rtl/memory_controller.sv | 94 +++++++++
 tb/tb_memory_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and geometry for the cache-miss memory controller.
// Addresses are {tag, index}; storage is one 3-bit word per address.
package mem_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 3;
    localparam int unsigned TAG_W     = 3;
    localparam int unsigned INDEX_W   = 2;
    localparam int unsigned MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    // Reset contents: each entry holds the low data bits of its own address.
    function automatic logic [DATA_W-1:0] init_word(input int unsigned idx);
        return DATA_W'(idx);
    endfunction

endpackage

// File: rtl/mem_array.sv
// 32 x 3-bit backing store: synchronous write, combinational read,
// synchronous reset that loads every entry with its address-derived value.
module mem_array
    import mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= init_word(i);
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/memory_controller.sv
// Cache-miss controller: optional dirty-line writeback, then refill, then a
// one-cycle response pulse. Each memory phase lasts LATENCY cycles.
module memory_controller
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wback,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [DATA_W-1:0] req_wb_data,
    input  logic [ADDR_W-1:0] req_fill_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    localparam logic [3:0] PHASE_LAST = 4'(LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        phase_cnt;
    logic              phase_last;
    logic              accept;

    logic              wback_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] fill_addr_q;

    logic              mem_we;
    logic [DATA_W-1:0] mem_rd_data;

    assign req_ready  = (state == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign phase_last = (phase_cnt == PHASE_LAST);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign mem_we     = (state == WB) && phase_last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = req_wback ? WB : FILL;
            WB:   if (phase_last) state_nxt = FILL;
            FILL: if (phase_last) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            resp_data   <= '0;
            wback_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            fill_addr_q <= '0;
        end else begin
            state <= state_nxt;
            // Counter only advances inside timed phases, so it never wraps.
            if (state_nxt != state) begin
                phase_cnt <= '0;
            end else if (state == WB || state == FILL) begin
                phase_cnt <= phase_cnt + 4'd1;
            end
            if (accept) begin
                wback_q     <= req_wback;
                wb_addr_q   <= req_wb_addr;
                wb_data_q   <= req_wb_data;
                fill_addr_q <= req_fill_addr;
            end
            if (state == FILL && phase_last) begin
                resp_data <= mem_rd_data;
            end
        end
    end

    mem_array u_mem_array (
        .clock   (clock),
        .reset   (reset),
        .we      (mem_we),
        .wr_addr (wb_addr_q),
        .wr_data (wb_data_q),
        .rd_addr (fill_addr_q),
        .rd_data (mem_rd_data)
    );

endmodule

// File: tb/tb_memory_controller.sv
// Randomized and directed bench for memory_controller against an array-based
// reference model; a second instance covers the minimum latency.
module tb_memory_controller;

    localparam int unsigned LAT  = 4;
    localparam int unsigned LAT1 = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wback = 1'b0;
    logic [4:0] req_wb_addr = '0;
    logic [2:0] req_wb_data = '0;
    logic [4:0] req_fill_addr = '0;
    logic       resp_valid;
    logic [2:0] resp_data;
    logic       busy;

    logic       l1_req_valid = 1'b0;
    logic       l1_req_ready;
    logic       l1_req_wback = 1'b0;
    logic [4:0] l1_req_wb_addr = '0;
    logic [2:0] l1_req_wb_data = '0;
    logic [4:0] l1_req_fill_addr = '0;
    logic       l1_resp_valid;
    logic [2:0] l1_resp_data;
    logic       l1_busy;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    logic [2:0] model_mem [32];
    logic [2:0] model_mem1 [32];

    always #5 clock = ~clock;

    memory_controller #(.LATENCY(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wback     (req_wback),
        .req_wb_addr   (req_wb_addr),
        .req_wb_data   (req_wb_data),
        .req_fill_addr (req_fill_addr),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .busy          (busy)
    );

    memory_controller #(.LATENCY(LAT1)) dut1 (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (l1_req_valid),
        .req_ready     (l1_req_ready),
        .req_wback     (l1_req_wback),
        .req_wb_addr   (l1_req_wb_addr),
        .req_wb_data   (l1_req_wb_data),
        .req_fill_addr (l1_req_fill_addr),
        .resp_valid    (l1_resp_valid),
        .resp_data     (l1_resp_data),
        .busy          (l1_busy)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            model_mem[i]  = 3'(i);
            model_mem1[i] = 3'(i);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        req_valid = 1'b1;
        req_wback = 1'b0;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 3'b000 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b resp_valid=%b resp_data=%b req_ready=%b, want 0 0 000 0",
                     busy, resp_valid, resp_data, req_ready);
        end
        req_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (req_ready !== 1'b1 || l1_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: req_ready=%b l1_req_ready=%b, want 1 1", req_ready, l1_req_ready);
        end
    endtask

    // One full transaction on the LATENCY=4 instance; garbage requests are
    // driven while busy and must be ignored.
    task automatic do_txn(input logic wb, input logic [4:0] wba, input logic [2:0] wbd,
                          input logic [4:0] fa, input string name);
        int unsigned cyc;
        int unsigned exp_cyc;
        logic [2:0]  exp_data;
        bit          seen;
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ready: req_ready=%b, want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_wback = wb;
        req_wb_addr = wba;
        req_wb_data = wbd;
        req_fill_addr = fa;
        @(posedge clock);
        if (wb) model_mem[wba] = wbd;
        exp_data = model_mem[fa];
        exp_cyc = wb ? 2 * LAT + 1 : LAT + 1;
        seen = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clock);
            cyc = k;
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                req_valid = 1'b0;
            end else begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s_busy: cycle %0d busy=%b, want 1", name, k, busy);
                end
                req_valid = 1'($urandom_range(0, 1));
                req_wback = 1'($urandom_range(0, 1));
                req_wb_addr = 5'($urandom);
                req_wb_data = 3'($urandom);
                req_fill_addr = 5'($urandom);
            end
        end
        tests_run++;
        if (!seen || cyc != exp_cyc) begin
            tests_failed++;
            $display("FAIL %s_latency: resp_valid at cycle %0d (seen=%0b), want cycle %0d", name, cyc, seen, exp_cyc);
        end
        tests_run++;
        if (resp_data !== exp_data) begin
            tests_failed++;
            $display("FAIL %s_data: resp_data=%b, want %b", name, resp_data, exp_data);
        end
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || resp_data !== exp_data) begin
            tests_failed++;
            $display("FAIL %s_after: resp_valid=%b busy=%b req_ready=%b resp_data=%b, want 0 0 1 %b",
                     name, resp_valid, busy, req_ready, resp_data, exp_data);
        end
    endtask

    task automatic test_directed();
        do_txn(1'b0, 5'h00, 3'b000, 5'h0B, "fill_0b");
        tests_run++;
        if (resp_data !== 3'b011) begin
            tests_failed++;
            $display("FAIL fill_0b_const: resp_data=%b, want 011", resp_data);
        end
        do_txn(1'b1, 5'h0B, 3'b110, 5'h0B, "wb_same_addr");
        tests_run++;
        if (resp_data !== 3'b110) begin
            tests_failed++;
            $display("FAIL wb_same_addr_const: resp_data=%b, want 110", resp_data);
        end
        do_txn(1'b1, 5'h02, 3'b101, 5'h13, "wb_other_addr");
        tests_run++;
        if (resp_data !== 3'b011) begin
            tests_failed++;
            $display("FAIL wb_other_addr_const: resp_data=%b, want 011", resp_data);
        end
        do_txn(1'b0, 5'h00, 3'b000, 5'h02, "refill_02");
        tests_run++;
        if (resp_data !== 3'b101) begin
            tests_failed++;
            $display("FAIL refill_02_const: resp_data=%b, want 101", resp_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            do_txn(1'($urandom_range(0, 1)), 5'($urandom), 3'($urandom), 5'($urandom), "random");
        end
        // Sweep every address once to catch aliasing.
        for (int a = 0; a < 32; a++) begin
            do_txn(1'b0, 5'h00, 3'b000, 5'(a), "sweep");
        end
    endtask

    task automatic test_back_to_back();
        int unsigned last_acc;
        int unsigned accepts;
        int unsigned gap;
        logic        prev_resp;
        logic [4:0]  a;
        a = 5'($urandom);
        @(negedge clock);
        req_valid = 1'b1;
        req_wback = 1'b1;
        req_wb_addr = a;
        req_wb_data = 3'b010;
        req_fill_addr = a;
        model_mem[a] = 3'b010;
        gap = 2 * LAT + 2;
        accepts = 0;
        last_acc = 0;
        prev_resp = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (req_ready === 1'b1) begin
                if (accepts > 0) begin
                    tests_run++;
                    if (k - last_acc != gap || prev_resp !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL b2b_gap: acceptance gap %0d prev_resp=%b, want %0d 1", k - last_acc, prev_resp, gap);
                    end
                end
                accepts++;
                last_acc = k;
            end else if (accepts > 0) begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_busy: cycle %0d busy=%b, want 1", k, busy);
                end
            end
            if (resp_valid === 1'b1) begin
                tests_run++;
                if (resp_data !== 3'b010) begin
                    tests_failed++;
                    $display("FAIL b2b_data: resp_data=%b, want 010", resp_data);
                end
            end
            prev_resp = resp_valid;
            @(negedge clock);
        end
        tests_run++;
        if (accepts != 60 / gap && accepts != 60 / gap + 1) begin
            tests_failed++;
            $display("FAIL b2b_count: %0d acceptances, want about %0d", accepts, 60 / gap);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 20 && busy === 1'b1; k++) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wb();
        bit got_resp;
        @(negedge clock);
        req_valid = 1'b1;
        req_wback = 1'b1;
        req_wb_addr = 5'h04;
        req_wb_data = 3'b010;
        req_fill_addr = 5'h1F;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        got_resp = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid === 1'b1 || busy === 1'b1) got_resp = 1'b1;
            @(negedge clock);
        end
        tests_run++;
        if (got_resp) begin
            tests_failed++;
            $display("FAIL reset_abort: resp_valid/busy seen after reset, want none");
        end
        do_txn(1'b0, 5'h00, 3'b000, 5'h04, "after_abort");
        tests_run++;
        if (resp_data !== 3'b100) begin
            tests_failed++;
            $display("FAIL after_abort_const: resp_data=%b, want 100", resp_data);
        end
    endtask

    task automatic test_latency1();
        int unsigned cyc;
        bit          seen;
        logic        wb;
        logic [4:0]  wba;
        logic [4:0]  fa;
        logic [2:0]  wbd;
        for (int n = 0; n < 6; n++) begin
            wb  = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            wba = 5'($urandom);
            wbd = 3'($urandom);
            fa  = (n == 0) ? 5'h0B : 5'($urandom);
            @(negedge clock);
            l1_req_valid = 1'b1;
            l1_req_wback = wb;
            l1_req_wb_addr = wba;
            l1_req_wb_data = wbd;
            l1_req_fill_addr = fa;
            @(posedge clock);
            if (wb) model_mem1[wba] = wbd;
            seen = 1'b0;
            cyc = 0;
            for (int k = 1; k <= 10 && !seen; k++) begin
                @(negedge clock);
                l1_req_valid = 1'b0;
                cyc = k;
                if (l1_resp_valid === 1'b1) seen = 1'b1;
            end
            tests_run++;
            if (!seen || cyc != (wb ? 3 : 2) || l1_resp_data !== model_mem1[fa]) begin
                tests_failed++;
                $display("FAIL lat1_txn: cycle %0d data %b (seen=%0b), want cycle %0d data %b",
                         cyc, l1_resp_data, seen, wb ? 3 : 2, model_mem1[fa]);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_wb();
        test_reset();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
